// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_pkg;
  typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA} arb_state_t;
  typedef logic [7:0] byte_t;
  localparam byte_t HDR_TAG = 8'hA0;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first set request at or above ptr, with wrap-around.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W:0] slot;

  // Walk from the farthest offset down so that the nearest hit is the one kept.
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    slot = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      slot = {1'b0, ptr} + (IDX_W+1)'(i);
      if (slot >= (IDX_W+1)'(N_REQ)) slot = slot - (IDX_W+1)'(N_REQ);
      if (req[slot[IDX_W-1:0]]) begin
        any = 1'b1;
        idx = slot[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one byte-level UART transmitter among N_REQ requesters, one packet or burst per grant.
//   state  | meaning
//   S_IDLE | no grant; pick the next requester round-robin from rr_ptr
//   S_HDR  | present header byte HDR_TAG | grant_idx until accepted
//   S_DATA | forward granted requester's bytes until last or burst limit
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int MAX_BURST = 16,
  parameter bit HDR_EN    = 1'b1,
  localparam int IDX_W    = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_data,
  input  logic [N_REQ-1:0]     req_last,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 tx_valid,
  output logic [7:0]           tx_data,
  input  logic                 tx_ready,
  output logic                 grant_active,
  output logic [IDX_W-1:0]     grant_idx
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);

  arb_state_t       state, state_nxt;
  logic [IDX_W-1:0] rr_ptr, rr_ptr_nxt, grant_nxt;
  logic [CNT_W-1:0] burst_cnt, burst_nxt;
  logic             arb_any;
  logic [IDX_W-1:0] arb_idx;
  logic             xfer;

  rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_rr (
    .req (req_valid),
    .ptr (rr_ptr),
    .any (arb_any),
    .idx (arb_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      grant_idx <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_ptr_nxt;
      grant_idx <= grant_nxt;
      burst_cnt <= burst_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    rr_ptr_nxt = rr_ptr;
    grant_nxt  = grant_idx;
    burst_nxt  = burst_cnt;
    tx_valid   = 1'b0;
    tx_data    = '0;
    req_ready  = '0;
    xfer       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (arb_any) begin
          grant_nxt = arb_idx;
          burst_nxt = '0;
          state_nxt = HDR_EN ? S_HDR : S_DATA;
        end
      end
      S_HDR: begin
        tx_valid = 1'b1;
        tx_data  = HDR_TAG | byte_t'(grant_idx);
        if (tx_ready) state_nxt = S_DATA;
      end
      S_DATA: begin
        tx_valid             = req_valid[grant_idx];
        tx_data              = req_data[{grant_idx, 3'b000} +: 8];
        req_ready[grant_idx] = tx_ready;
        xfer                 = tx_valid && tx_ready;
        if (xfer) begin
          burst_nxt = burst_cnt + 1'b1;
          // Burst limit releases the grant even mid-packet; the rest waits for a new turn.
          if (req_last[grant_idx] || burst_cnt == LAST_CNT) begin
            state_nxt  = S_IDLE;
            rr_ptr_nxt = (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign grant_active = (state != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: scripted requester packets, logged transmitter bytes.
module tb_uart_tx_arbiter;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid, req_last, req_ready;
  logic [8*N-1:0] req_data;
  logic           tx_valid, tx_ready, grant_active;
  logic [7:0]     tx_data;
  logic [1:0]     grant_idx;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N_REQ(N), .MAX_BURST(16), .HDR_EN(1'b1)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .tx_ready     (tx_ready),
    .grant_active (grant_active),
    .grant_idx    (grant_idx)
  );

  int         n_vec = 0, n_err = 0;
  logic [7:0] src_mem [N][32];
  bit         src_lst [N][32];
  int         src_len [N], src_pos [N], rdy_cnt [N];
  bit         hold [N];
  logic [7:0] tx_log [$], exp_q [$];
  logic       s_tx_valid, s_active;
  logic [7:0] s_tx_data;
  logic [N-1:0] s_req_ready;
  logic [1:0] s_idx;
  logic [6:0] act_hist;

  task automatic check(string tag, int obs, int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_src();
    for (int i = 0; i < N; i++) begin
      src_len[i] = 0; src_pos[i] = 0; hold[i] = 1'b0; rdy_cnt[i] = 0;
    end
  endtask

  task automatic add(int r, logic [7:0] d, bit last);
    src_mem[r][src_len[r]] = d;
    src_lst[r][src_len[r]] = last;
    src_len[r]++;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (!hold[i] && src_pos[i] < src_len[i]) begin
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = src_mem[i][src_pos[i]];
        req_last[i]        = src_lst[i][src_pos[i]];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
  endtask

  // One clock: present inputs, sample at negedge, retire accepted bytes after the posedge.
  task automatic step();
    bit pop [N];
    drive();
    @(negedge clk);
    s_tx_valid  = tx_valid;
    s_tx_data   = tx_data;
    s_req_ready = req_ready;
    s_active    = grant_active;
    s_idx       = grant_idx;
    if (tx_valid && tx_ready) tx_log.push_back(tx_data);
    for (int i = 0; i < N; i++) begin
      pop[i] = req_valid[i] && req_ready[i];
      if (req_ready[i]) rdy_cnt[i]++;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (pop[i]) src_pos[i]++;
  endtask

  function automatic bit drained();
    for (int i = 0; i < N; i++) if (src_pos[i] < src_len[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic run_idle(string tag, int max_cyc);
    bit done = 1'b0;
    for (int k = 0; k < max_cyc && !done; k++) begin
      step();
      if (!s_active && drained()) done = 1'b1;
    end
    check({tag, "_done"}, int'(done), 1);
  endtask

  task automatic cmp_log(string tag);
    check({tag, "_len"}, tx_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < tx_log.size()) check($sformatf("%s_b%0d", tag, i), int'(tx_log[i]), int'(exp_q[i]));
    tx_log.delete();
  endtask

  task automatic check_idle(string tag);
    check({tag, "_txv"}, int'(s_tx_valid), 0);
    check({tag, "_rdy"}, int'(s_req_ready), 0);
    check({tag, "_act"}, int'(s_active), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; tx_ready = 1'b0;
    clear_src();
    drive();
    repeat (3) step();
    check_idle("rst");
    check("rst_txd", int'(s_tx_data), 8'h00);
    check("rst_idx", int'(s_idx), 0);
    reset = 1'b0;
    tx_log.delete();

    // Single requester 2: header A2 one cycle after valid, then 55.
    tx_ready = 1'b1;
    add(2, 8'h55, 1'b1);
    step();
    check("t1_lat_idle", int'(s_tx_valid), 0);
    step();
    check("t1_hdr_txv", int'(s_tx_valid), 1);
    check("t1_hdr_txd", int'(s_tx_data), 8'hA2);
    check("t1_idx", int'(s_idx), 2);
    run_idle("t1", 10);
    check("t1_rdy_pulses", rdy_cnt[2], 1);
    exp_q = '{8'hA2, 8'h55};
    cmp_log("t1");

    // All four valid; pointer is 3 after serving requester 2.
    clear_src();
    for (int i = 0; i < N; i++) add(i, 8'hD0 + 8'(i), 1'b1);
    run_idle("t2", 40);
    exp_q = '{8'hA3, 8'hD3, 8'hA0, 8'hD0, 8'hA1, 8'hD1, 8'hA2, 8'hD2};
    cmp_log("t2");

    // Reset restores pointer 0; 20-byte packet split at 16 around requester 3.
    clear_src();
    reset = 1'b1; step(); reset = 1'b0;
    tx_log.delete();
    for (int k = 0; k < 20; k++) add(1, 8'h10 + 8'(k), k == 19);
    add(3, 8'hC0, 1'b0);
    add(3, 8'hC1, 1'b1);
    run_idle("t3", 100);
    exp_q.delete();
    exp_q.push_back(8'hA1);
    for (int k = 0; k < 16; k++) exp_q.push_back(8'h10 + 8'(k));
    exp_q.push_back(8'hA3); exp_q.push_back(8'hC0); exp_q.push_back(8'hC1);
    exp_q.push_back(8'hA1);
    for (int k = 16; k < 20; k++) exp_q.push_back(8'h10 + 8'(k));
    cmp_log("t3");

    // Backpressure in header and data phases.
    clear_src();
    tx_ready = 1'b0;
    add(0, 8'h31, 1'b0); add(0, 8'h32, 1'b0); add(0, 8'h33, 1'b1);
    step();
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("t4_hdr_txv%0d", k), int'(s_tx_valid), 1);
      check($sformatf("t4_hdr_txd%0d", k), int'(s_tx_data), 8'hA0);
      check($sformatf("t4_hdr_rdy%0d", k), int'(s_req_ready), 0);
    end
    tx_ready = 1'b1;
    step();
    step();
    tx_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("t4_dat_txv%0d", k), int'(s_tx_valid), 1);
      check($sformatf("t4_dat_txd%0d", k), int'(s_tx_data), 8'h32);
      check($sformatf("t4_dat_rdy%0d", k), int'(s_req_ready), 0);
    end
    tx_ready = 1'b1;
    run_idle("t4", 20);
    exp_q = '{8'hA0, 8'h31, 8'h32, 8'h33};
    cmp_log("t4");

    // Granted requester pauses mid-packet.
    clear_src();
    for (int k = 0; k < 4; k++) add(1, 8'h41 + 8'(k), k == 3);
    repeat (4) step();
    hold[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("t5_gap_txv%0d", k), int'(s_tx_valid), 0);
      check($sformatf("t5_gap_act%0d", k), int'(s_active), 1);
      check($sformatf("t5_gap_idx%0d", k), int'(s_idx), 1);
    end
    hold[1] = 1'b0;
    run_idle("t5", 20);
    exp_q = '{8'hA1, 8'h41, 8'h42, 8'h43, 8'h44};
    cmp_log("t5");

    // Reset while byte 3 is on the bus; new grant order restarts from 0.
    clear_src();
    for (int k = 0; k < 6; k++) add(2, 8'h61 + 8'(k), k == 5);
    repeat (4) step();
    reset = 1'b1;
    step();
    check("t6_pre_txd", int'(s_tx_data), 8'h63);
    reset = 1'b0;
    tx_log.delete();
    add(0, 8'h77, 1'b1);
    step();
    check_idle("t6_post");
    run_idle("t6", 30);
    exp_q = '{8'hA0, 8'h77, 8'hA2, 8'h64, 8'h65, 8'h66};
    cmp_log("t6");

    // Lone requester with two packets: re-granted after one idle cycle.
    clear_src();
    add(0, 8'hB1, 1'b1);
    add(0, 8'hB2, 1'b1);
    act_hist = '0;
    for (int k = 0; k < 7; k++) begin
      step();
      act_hist = {act_hist[5:0], s_active};
    end
    check("t7_act_seq", int'(act_hist), 7'b0110110);
    exp_q = '{8'hA0, 8'hB1, 8'hA0, 8'hB2};
    cmp_log("t7");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
